// File: rtl/snap_rd_unloader.sv
// -----------------------------------------------------------------------------
// snap_rd_unloader
//
// Purpose:
//   Read-side counterpart of the write-side hold latches. A one-cycle strobe
//   (snap) captures a wide status/counter word into a shadow register in one
//   clock. The host then reads that shadow out as WW-bit words, least
//   significant word first. Each host read strobe (rd) advances to the next
//   word. Because the host only ever sees the frozen shadow, a value that
//   spans several words cannot be torn by a datapath update that lands
//   between two host reads.
//
// Parameters:
//   DW  snapshot width in bits. When DW is not a multiple of WW, the top word
//       is zero-padded.
//   WW  host read word width in bits.
//   NW  derived word count, (DW+WW-1)/WW. Always at least 1.
//
// Ports:
//   clk       in   1   system clock; all state changes on posedge
//   rst_n     in   1   asynchronous active-low reset
//   snap      in   1   one-cycle capture strobe; accepted only while idle
//   din       in   DW  live value, sampled only on an accepted snap
//   rd        in   1   host read strobe; consumes the current word
//   dout      out  WW  current snapshot word (registered)
//   dout_vld  out  1   a snapshot word is presented on dout
//   last      out  1   the word on dout is the final word of the snapshot
//   busy      out  1   an unload is in progress
//   ovfl      out  1   sticky snapshot-overrun flag
//
// Configuration:
//   SNAP_RD_OVERRUN_EN  When defined, ovfl is set by any snap that arrives
//                       during an unload. It is cleared by the next accepted
//                       snap. When undefined, ovfl is tied to 0. The rejection
//                       of such snaps is the same in both builds.
// -----------------------------------------------------------------------------
module snap_rd_unloader #(
   parameter int DW = 48,
   parameter int WW = 16
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          snap,
   input  logic [DW-1:0] din,
   input  logic          rd,
   output logic [WW-1:0] dout,
   output logic          dout_vld,
   output logic          last,
   output logic          busy,
   output logic          ovfl
);

   localparam int NW = (DW + WW - 1) / WW;
   localparam int IW = (NW > 1) ? $clog2(NW) : 1;
   localparam int SW = NW * WW;

   localparam logic [IW-1:0] LAST_IDX = IW'(NW - 1);

   localparam logic [0:0] IDLE = 1'b0;
   localparam logic [0:0] SEND = 1'b1;

   logic [0:0]    state_q,  state_d;
   logic [SW-1:0] shadow_q, shadow_d;
   logic [IW-1:0] idx_q,    idx_d;
   logic [WW-1:0] dout_q,   dout_d;
   logic          vld_q,    vld_d;

   logic [SW-1:0] din_pad;
   logic [IW-1:0] idx_nxt;
   logic [WW-1:0] next_word;

   // Zero-extend din to a whole number of words so the top word's pad bits
   // are deterministic.
   always_comb begin
      // NOTE: every signal written in a combinational block gets a default
      // first, so no path through the block can leave it unassigned and
      // infer a latch.
      din_pad          = '0;
      din_pad[DW-1:0]  = din;
   end

   // The next word is selected from the frozen shadow with a plain
   // compare-mux. This keeps the select in range even when NW==1, where the
   // SEND advance path can never be taken.
   always_comb begin
      idx_nxt   = IW'(idx_q + 1'b1);
      next_word = '0;
      for (int w = 0; w < NW; w++) begin
         if (idx_nxt == IW'(w)) begin
            next_word = shadow_q[w*WW +: WW];
         end
      end
   end

   always_comb begin
      state_d  = state_q;
      shadow_d = shadow_q;
      idx_d    = idx_q;
      dout_d   = dout_q;
      vld_d    = vld_q;

      case (state_q)
         IDLE: begin
            // rd is ignored here. A snap loads the shadow and presents
            // word 0 on the following cycle.
            if (snap) begin
               shadow_d = din_pad;
               idx_d    = '0;
               dout_d   = din_pad[WW-1:0];
               vld_d    = 1'b1;
               state_d  = SEND;
            end
         end

         SEND: begin
            // A snap here is rejected. The shadow being unloaded is never
            // touched.
            if (rd) begin
               if (idx_q == LAST_IDX) begin
                  state_d = IDLE;
                  idx_d   = '0;
                  dout_d  = '0;
                  vld_d   = 1'b0;
               end else begin
                  idx_d   = idx_nxt;
                  dout_d  = next_word;
               end
            end
         end

         default: begin
            state_d = IDLE;
            idx_d   = '0;
            dout_d  = '0;
            vld_d   = 1'b0;
         end
      endcase
   end

   // NOTE: sequential state is updated with non-blocking assignments. Every
   // register then samples values from before the edge, whatever order the
   // blocks are evaluated in.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         idx_q   <= '0;
         dout_q  <= '0;
         vld_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         dout_q  <= dout_d;
         vld_q   <= vld_d;
      end
   end

   // NOTE: the shadow is a wide storage register, but it is still cleared on
   // reset. A reset mid-unload must leave no trace of the abandoned snapshot.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         shadow_q <= '0;
      end else begin
         shadow_q <= shadow_d;
      end
   end

`ifdef SNAP_RD_OVERRUN_EN
   logic ovfl_q, ovfl_d;

   // Set by a snap that arrives while unloading. Cleared only by the next
   // accepted snap. The two conditions depend on the state, so they can
   // never coincide.
   always_comb begin
      ovfl_d = ovfl_q;
      if (snap) begin
         if (state_q == SEND) begin
            ovfl_d = 1'b1;
         end else begin
            ovfl_d = 1'b0;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ovfl_q <= 1'b0;
      end else begin
         ovfl_q <= ovfl_d;
      end
   end

   assign ovfl = ovfl_q;
`else
   assign ovfl = 1'b0;
`endif

   assign dout     = dout_q;
   assign dout_vld = vld_q;
   assign last     = vld_q && (idx_q == LAST_IDX);
   assign busy     = (state_q == SEND);

endmodule

// File: tb/tb_snap_rd_unloader.sv
// -----------------------------------------------------------------------------
// tb_snap_rd_unloader
//
// Directed bench for snap_rd_unloader. It uses three instances:
//   u_dut    DW=48, WW=16  (NW=3)  main behaviour, atomicity, overrun, reset
//   u_dut20  DW=20, WW=16  (NW=2)  zero-padded top word
//   u_dut16  DW=16, WW=16  (NW=1)  single-word snapshot
// Inputs change 1 ns after a rising edge. Outputs are sampled at the same
// point, well away from the next active edge.
// -----------------------------------------------------------------------------
module tb_snap_rd_unloader;

   logic clk;
   logic rst_n;

   // Main instance.
   logic        snap, rd;
   logic [47:0] din;
   logic [15:0] dout;
   logic        dout_vld, last, busy, ovfl;

   // DW=20 instance.
   logic        snap20, rd20;
   logic [19:0] din20;
   logic [15:0] dout20;
   logic        vld20, last20, busy20, ovfl20;

   // DW=16 instance.
   logic        snap16, rd16;
   logic [15:0] din16;
   logic [15:0] dout16;
   logic        vld16, last16, busy16, ovfl16;

`ifdef SNAP_RD_OVERRUN_EN
   localparam logic OVR = 1'b1;
`else
   localparam logic OVR = 1'b0;
`endif

   int checks   = 0;
   int failures = 0;

   snap_rd_unloader #(.DW(48), .WW(16)) u_dut (
      .clk(clk), .rst_n(rst_n), .snap(snap), .din(din), .rd(rd),
      .dout(dout), .dout_vld(dout_vld), .last(last), .busy(busy), .ovfl(ovfl)
   );

   snap_rd_unloader #(.DW(20), .WW(16)) u_dut20 (
      .clk(clk), .rst_n(rst_n), .snap(snap20), .din(din20), .rd(rd20),
      .dout(dout20), .dout_vld(vld20), .last(last20), .busy(busy20), .ovfl(ovfl20)
   );

   snap_rd_unloader #(.DW(16), .WW(16)) u_dut16 (
      .clk(clk), .rst_n(rst_n), .snap(snap16), .din(din16), .rd(rd16),
      .dout(dout16), .dout_vld(vld16), .last(last16), .busy(busy16), .ovfl(ovfl16)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Advance one clock and land 1 ns after the rising edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Compare every output of the main instance against expected values.
   task automatic expect_main(input string tag, input logic [15:0] e_dout, input logic e_vld,
                              input logic e_last, input logic e_busy, input logic e_ovfl);
      check({tag, ".dout"}, 64'(dout),     64'(e_dout));
      check({tag, ".vld"},  64'(dout_vld), 64'(e_vld));
      check({tag, ".last"}, 64'(last),     64'(e_last));
      check({tag, ".busy"}, 64'(busy),     64'(e_busy));
      check({tag, ".ovfl"}, 64'(ovfl),     64'(e_ovfl));
   endtask

   initial begin
      rst_n = 1'b0;
      snap = 1'b0; rd = 1'b0; din = '0;
      snap20 = 1'b0; rd20 = 1'b0; din20 = '0;
      snap16 = 1'b0; rd16 = 1'b0; din16 = '0;

      // Reset state.
      #3;
      expect_main("reset", 16'h0, 1'b0, 1'b0, 1'b0, 1'b0);
      check("reset.vld20", 64'(vld20), 64'd0);
      check("reset.vld16", 64'(vld16), 64'd0);
      #10 rst_n = 1'b1;
      tick();
      expect_main("post_reset", 16'h0, 1'b0, 1'b0, 1'b0, 1'b0);

      // Basic capture, then back-to-back reads.
      din = 48'h1234_5678_9ABC; snap = 1'b1;
      tick();
      snap = 1'b0;
      expect_main("t1.w0", 16'h9ABC, 1'b1, 1'b0, 1'b1, 1'b0);
      rd = 1'b1;
      tick();
      expect_main("t1.w1", 16'h5678, 1'b1, 1'b0, 1'b1, 1'b0);
      tick();
      expect_main("t1.w2", 16'h1234, 1'b1, 1'b1, 1'b1, 1'b0);
      tick();
      rd = 1'b0;
      expect_main("t1.done", 16'h0, 1'b0, 1'b0, 1'b0, 1'b0);

      // rd while idle does nothing.
      rd = 1'b1;
      repeat (3) tick();
      rd = 1'b0;
      expect_main("idle_rd", 16'h0, 1'b0, 1'b0, 1'b0, 1'b0);

      // Atomicity: din changes after the snap; reads are spaced 5 cycles apart.
      din = 48'h1234_5678_9ABC; snap = 1'b1;
      tick();
      snap = 1'b0; din = 48'hFFFF_FFFF_FFFF;
      repeat (4) tick();
      expect_main("t2.w0", 16'h9ABC, 1'b1, 1'b0, 1'b1, 1'b0);
      rd = 1'b1; tick(); rd = 1'b0;
      repeat (4) tick();
      expect_main("t2.w1", 16'h5678, 1'b1, 1'b0, 1'b1, 1'b0);
      rd = 1'b1; tick(); rd = 1'b0;
      repeat (4) tick();
      expect_main("t2.w2", 16'h1234, 1'b1, 1'b1, 1'b1, 1'b0);
      rd = 1'b1; tick(); rd = 1'b0;
      expect_main("t2.done", 16'h0, 1'b0, 1'b0, 1'b0, 1'b0);

      // A snap during the unload is rejected and, when enabled, raises ovfl.
      din = 48'h1234_5678_9ABC; snap = 1'b1;
      tick();
      snap = 1'b0;
      rd = 1'b1; tick(); rd = 1'b0;
      expect_main("t3.w1", 16'h5678, 1'b1, 1'b0, 1'b1, 1'b0);
      din = 48'h0; snap = 1'b1;
      tick();
      snap = 1'b0;
      expect_main("t3.rej", 16'h5678, 1'b1, 1'b0, 1'b1, OVR);
      rd = 1'b1; tick(); rd = 1'b0;
      expect_main("t3.w2", 16'h1234, 1'b1, 1'b1, 1'b1, OVR);
      rd = 1'b1; tick(); rd = 1'b0;
      expect_main("t3.done", 16'h0, 1'b0, 1'b0, 1'b0, OVR);
      tick();
      expect_main("t3.sticky", 16'h0, 1'b0, 1'b0, 1'b0, OVR);

      // The next accepted snap clears ovfl.
      din = 48'hCAFE_0000_BEEF; snap = 1'b1;
      tick();
      snap = 1'b0;
      expect_main("t4.w0", 16'hBEEF, 1'b1, 1'b0, 1'b1, 1'b0);
      rd = 1'b1; tick(); tick();
      rd = 1'b0;
      expect_main("t4.w2", 16'hCAFE, 1'b1, 1'b1, 1'b1, 1'b0);

      // A snap in the same cycle as the final rd is still rejected.
      din = 48'h1111_2222_3333; snap = 1'b1; rd = 1'b1;
      tick();
      snap = 1'b0; rd = 1'b0;
      expect_main("t4.same", 16'h0, 1'b0, 1'b0, 1'b0, OVR);
      tick();
      expect_main("t4.same2", 16'h0, 1'b0, 1'b0, 1'b0, OVR);

      // Asynchronous reset mid-unload (idx=1).
      din = 48'hAAAA_BBBB_CCCC; snap = 1'b1;
      tick();
      snap = 1'b0;
      rd = 1'b1; tick(); rd = 1'b0;
      expect_main("t5.w1", 16'hBBBB, 1'b1, 1'b0, 1'b1, 1'b0);
      #2 rst_n = 1'b0;
      #1;
      expect_main("t5.async", 16'h0, 1'b0, 1'b0, 1'b0, 1'b0);
      #3 rst_n = 1'b1;
      tick();
      rd = 1'b1; tick(); rd = 1'b0;
      expect_main("t5.idle", 16'h0, 1'b0, 1'b0, 1'b0, 1'b0);

      // DW=20: the top word is zero-padded.
      din20 = 20'hABCDE; snap20 = 1'b1;
      tick();
      snap20 = 1'b0;
      check("d20.w0",   64'(dout20), 64'h BCDE);
      check("d20.last0", 64'(last20), 64'd0);
      rd20 = 1'b1; tick(); rd20 = 1'b0;
      check("d20.w1",   64'(dout20), 64'h000A);
      check("d20.last1", 64'(last20), 64'd1);
      rd20 = 1'b1; tick(); rd20 = 1'b0;
      check("d20.vld",  64'(vld20),  64'd0);
      check("d20.busy", 64'(busy20), 64'd0);

      // NW=1: a single rd drains the snapshot.
      din16 = 16'h5A5A; snap16 = 1'b1;
      tick();
      snap16 = 1'b0;
      check("d16.w0",   64'(dout16), 64'h5A5A);
      check("d16.last", 64'(last16), 64'd1);
      check("d16.busy", 64'(busy16), 64'd1);
      repeat (2) tick();
      check("d16.hold", 64'(dout16), 64'h5A5A);
      rd16 = 1'b1; tick(); rd16 = 1'b0;
      check("d16.vld",  64'(vld16),  64'd0);
      check("d16.busy0", 64'(busy16), 64'd0);
      check("d16.dout0", 64'(dout16), 64'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
